// File: rtl/cyc_sampler_pkg.sv
// Shared types and constants for the cycle-counter sampler.
//   SEQ_W    : width of the per-sample sequence tag
//   DROP_W   : width of the saturating drop counter
//   SAMPLE_W : default sample data width
//   sample_t : FIFO entry {seq, data} at the default width
package cyc_sampler_pkg;

  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned DROP_W   = 16;
  localparam int unsigned SAMPLE_W = 32;

  localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

  typedef struct packed {
    logic [SEQ_W-1:0]    seq;
    logic [SAMPLE_W-1:0] data;
  } sample_t;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/cyc_sampler_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head entry.
//   clk, reset_l : clock, synchronous active-low reset
//   push, wdata  : write request and entry (ignored when full without pop)
//   pop          : read request (ignored when empty)
//   head, vld    : registered head entry and non-empty flag
//   level        : registered occupancy, 0..DEPTH
module cyc_sampler_fifo
  import cyc_sampler_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = sample_t
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   vld,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  entry_t           head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             vld_q, vld_d;
  logic             push_ok, pop_ok;

  // Pointer/level update and head refresh.
  always_comb begin
    pop_ok   = pop && vld_q;
    push_ok  = push && ((level_q < LVL_W'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LVL_W'(1);

    // The head register mirrors mem[rd_ptr]. With more than one entry the
    // successor is already in memory; with exactly one, a concurrent write
    // becomes the new head. An empty FIFO loads the write next cycle.
    if (pop_ok) begin
      if (level_q > LVL_W'(1)) head_d = mem_q[rd_ptr_d];
      else if (push_ok)        head_d = wdata;
    end else if ((level_q == '0) && push_ok) begin
      head_d = wdata;
    end

    vld_d = (level_d != '0);
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
    end
  end

  // Storage array; contents are don't-care until pointed at.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = head_q;
  assign vld   = vld_q;
  assign level = level_q;

endmodule

// File: rtl/cyc_sampler.sv
// Decimating sampler for the upstream cycle counter.
//   clk, reset_l     : clock, synchronous active-low reset
//   in_vld, in_cyc   : upstream counter value and its valid
//   out_vld, out_rdy : sink handshake for the FIFO head
//   out_data/out_seq : head sample value and its sequence tag
//   level            : FIFO occupancy
//   drop_cnt         : saturating count of samples lost to a full FIFO
//   done             : sticky, set when FINISH_CYC is accepted
module cyc_sampler
  import cyc_sampler_pkg::*;
#(
  parameter int unsigned WIDTH      = SAMPLE_W,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DECIM      = 1,
  parameter int unsigned FINISH_CYC = 5
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   in_vld,
  input  logic [WIDTH-1:0]       in_cyc,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   done
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              done_q, done_d;
  logic              accept, take, pop, room, push;
  entry_t            wr_entry, head_entry;
  logic              fifo_vld;
  logic [LVL_W-1:0]  fifo_level;

  // Accept, decimate, tag, and decide push versus drop.
  always_comb begin
    accept     = in_vld && !done_q;
    take       = accept && (dec_cnt_q == '0);
    pop        = fifo_vld && out_rdy;
    room       = (fifo_level < LVL_W'(DEPTH)) || pop;
    push       = take && room;
    wr_entry   = '{seq: seq_cnt_q, data: in_cyc};
    dec_cnt_d  = dec_cnt_q;
    seq_cnt_d  = seq_cnt_q;
    drop_cnt_d = drop_cnt_q;
    done_d     = done_q;

    if (accept) begin
      dec_cnt_d = (dec_cnt_q == DEC_W'(DECIM - 1)) ? '0 : dec_cnt_q + DEC_W'(1);
    end
    // Sequence advances on drops too, so gaps in out_seq reveal losses.
    if (take)          seq_cnt_d  = seq_cnt_q + SEQ_W'(1);
    if (take && !room) drop_cnt_d = sat_inc(drop_cnt_q);
    if (accept && (in_cyc == WIDTH'(FINISH_CYC))) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      dec_cnt_q  <= '0;
      seq_cnt_q  <= '0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      dec_cnt_q  <= dec_cnt_d;
      seq_cnt_q  <= seq_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      done_q     <= done_d;
    end
  end

  cyc_sampler_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_l (reset_l),
    .push    (push),
    .wdata   (wr_entry),
    .pop     (pop),
    .head    (head_entry),
    .vld     (fifo_vld),
    .level   (fifo_level)
  );

  assign out_vld  = fifo_vld;
  assign out_data = head_entry.data;
  assign out_seq  = head_entry.seq;
  assign level    = fifo_level;
  assign drop_cnt = drop_cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cyc_sampler.sv
// Bench for cyc_sampler: per-cycle vector table plus an ordered scoreboard,
// a backpressure sequence, and a DECIM=3 instance.
module tb_cyc_sampler;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_l;
  logic         a_in_vld, a_out_rdy, a_out_vld, a_done;
  logic [W-1:0] a_in_cyc, a_out_data;
  logic [7:0]   a_out_seq;
  logic [2:0]   a_level;
  logic [15:0]  a_drop;

  logic         b_in_vld, b_out_rdy, b_out_vld, b_done;
  logic [W-1:0] b_in_cyc, b_out_data;
  logic [7:0]   b_out_seq;
  logic [2:0]   b_level;
  logic [15:0]  b_drop;

  cyc_sampler #(.WIDTH(W), .DEPTH(4), .DECIM(1), .FINISH_CYC(5)) u_a (
    .clk(clk), .reset_l(reset_l), .in_vld(a_in_vld), .in_cyc(a_in_cyc),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_data(a_out_data),
    .out_seq(a_out_seq), .level(a_level), .drop_cnt(a_drop), .done(a_done));

  cyc_sampler #(.WIDTH(W), .DEPTH(4), .DECIM(3), .FINISH_CYC(1000)) u_b (
    .clk(clk), .reset_l(reset_l), .in_vld(b_in_vld), .in_cyc(b_in_cyc),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_data(b_out_data),
    .out_seq(b_out_seq), .level(b_level), .drop_cnt(b_drop), .done(b_done));

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  seq;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t tmp_e;

  typedef struct {
    bit rst;
    bit vld;
    int cyc;
    bit rdy;
    bit ev;
    int ed;
    int es;
    int el;
    int edr;
    bit edn;
    bit sb;
    int sseq;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void r(bit rst, bit vld, int cyc, bit rdy, bit ev, int ed, int es,
                            int el, int edr, bit edn, bit sb, int sseq);
    vec_t t;
    t.rst = rst; t.vld = vld; t.cyc = cyc; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.es = es; t.el = el; t.edr = edr; t.edn = edn;
    t.sb = sb; t.sseq = sseq;
    tbl.push_back(t);
  endfunction

  task automatic do_reset();
    reset_l   = 1'b0;
    a_in_vld  = 1'b0;
    a_out_rdy = 1'b0;
    b_in_vld  = 1'b0;
    b_out_rdy = 1'b0;
    sb_q.delete();
    step();
    reset_l = 1'b1;
  endtask

  // Scoreboard: every handshake on instance A must match the next expected entry.
  always @(negedge clk) begin
    if (reset_l === 1'b1 && a_out_vld === 1'b1 && a_out_rdy === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got data %0d seq %0d want no output", a_out_data, a_out_seq);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_data", 64'(a_out_data), 64'(mon_e.data));
        chk("sb_seq", 64'(a_out_seq), 64'(mon_e.seq));
      end
    end
  end

  logic       pv, pr;
  logic [31:0] pd;
  logic [7:0]  ps;
  int          bp_seq;
  bit          ev;

  initial begin
    reset_l  = 1'b0;
    a_in_vld = 1'b0; a_in_cyc = '0; a_out_rdy = 1'b0;
    b_in_vld = 1'b0; b_in_cyc = '0; b_out_rdy = 1'b0;

    // rst vld cyc rdy | ev ed es el edr edn | sb sseq
    // In-order stream 0..5 with finish at 5, then ignored inputs.
    r(1,0, 0,0, 0, 0,0,0,0,0, 0,0);
    r(0,1, 0,1, 1, 0,0,1,0,0, 1,0);
    r(0,1, 1,1, 1, 1,1,1,0,0, 1,1);
    r(0,1, 2,1, 1, 2,2,1,0,0, 1,2);
    r(0,1, 3,1, 1, 3,3,1,0,0, 1,3);
    r(0,1, 4,1, 1, 4,4,1,0,0, 1,4);
    r(0,1, 5,1, 1, 5,5,1,0,1, 1,5);
    r(0,1, 6,1, 0, 0,0,0,0,1, 0,0);
    r(0,1, 7,1, 0, 0,0,0,0,1, 0,0);
    // Fill without ready, two drops, drain, then seq gap shows on next push.
    r(1,0, 0,0, 0, 0,0,0,0,0, 0,0);
    r(0,1,10,0, 1,10,0,1,0,0, 1,0);
    r(0,1,11,0, 1,10,0,2,0,0, 1,1);
    r(0,1,12,0, 1,10,0,3,0,0, 1,2);
    r(0,1,13,0, 1,10,0,4,0,0, 1,3);
    r(0,1,14,0, 1,10,0,4,1,0, 0,0);
    r(0,1,15,0, 1,10,0,4,2,0, 0,0);
    r(0,0, 0,1, 1,11,1,3,2,0, 0,0);
    r(0,0, 0,1, 1,12,2,2,2,0, 0,0);
    r(0,0, 0,1, 1,13,3,1,2,0, 0,0);
    r(0,0, 0,1, 0, 0,0,0,2,0, 0,0);
    r(0,1,20,1, 1,20,6,1,2,0, 1,6);
    r(0,0, 0,1, 0, 0,0,0,2,0, 0,0);
    // Full FIFO with push and pop in the same cycle.
    r(1,0, 0,0, 0, 0,0,0,0,0, 0,0);
    r(0,1,30,0, 1,30,0,1,0,0, 1,0);
    r(0,1,31,0, 1,30,0,2,0,0, 1,1);
    r(0,1,32,0, 1,30,0,3,0,0, 1,2);
    r(0,1,33,0, 1,30,0,4,0,0, 1,3);
    r(0,1,34,1, 1,31,1,4,0,0, 1,4);
    r(0,0, 0,1, 1,32,2,3,0,0, 0,0);
    r(0,0, 0,1, 1,33,3,2,0,0, 0,0);
    r(0,0, 0,1, 1,34,4,1,0,0, 0,0);
    r(0,0, 0,1, 0, 0,0,0,0,0, 0,0);
    // Drop, finish while non-empty, ignored input, then reset with 3 queued.
    r(1,0, 0,0, 0, 0,0,0,0,0, 0,0);
    r(0,1, 7,0, 1, 7,0,1,0,0, 1,0);
    r(0,1, 8,0, 1, 7,0,2,0,0, 1,1);
    r(0,1, 9,0, 1, 7,0,3,0,0, 1,2);
    r(0,1,10,0, 1, 7,0,4,0,0, 1,3);
    r(0,1,11,0, 1, 7,0,4,1,0, 0,0);
    r(0,0, 0,1, 1, 8,1,3,1,0, 0,0);
    r(0,1, 5,0, 1, 8,1,4,1,1, 1,5);
    r(0,1,12,1, 1, 9,2,3,1,1, 0,0);
    r(1,0, 0,0, 0, 0,0,0,0,0, 0,0);
    r(0,1,40,1, 1,40,0,1,0,0, 1,0);
    r(0,0, 0,1, 0, 0,0,0,0,0, 0,0);

    foreach (tbl[k]) begin
      v = tbl[k];
      reset_l   = !v.rst;
      a_in_vld  = v.vld;
      a_in_cyc  = 32'(v.cyc);
      a_out_rdy = v.rdy;
      if (v.rst) sb_q.delete();
      if (v.sb) begin
        tmp_e.seq  = 8'(v.sseq);
        tmp_e.data = 32'(v.cyc);
        sb_q.push_back(tmp_e);
      end
      step();
      chk($sformatf("r%0d_vld", k), 64'(a_out_vld), 64'(v.ev));
      chk($sformatf("r%0d_level", k), 64'(a_level), 64'(v.el));
      chk($sformatf("r%0d_drop", k), 64'(a_drop), 64'(v.edr));
      chk($sformatf("r%0d_done", k), 64'(a_done), 64'(v.edn));
      if (v.ev || v.rst) begin
        chk($sformatf("r%0d_data", k), 64'(a_out_data), 64'(v.ed));
        chk($sformatf("r%0d_seq", k), 64'(a_out_seq), 64'(v.es));
      end
    end

    // Backpressure: ready toggles every cycle; the head must hold while stalled.
    do_reset();
    bp_seq = 0;
    for (int i = 0; i < 30; i++) begin
      pv = a_out_vld;
      pd = a_out_data;
      ps = a_out_seq;
      a_in_vld  = (i % 3 == 0);
      a_in_cyc  = 32'(100 + i);
      a_out_rdy = i[0];
      pr = a_out_rdy;
      if (a_in_vld) begin
        tmp_e.seq  = 8'(bp_seq);
        tmp_e.data = 32'(100 + i);
        sb_q.push_back(tmp_e);
        bp_seq++;
      end
      step();
      if (pv && !pr) begin
        chk("bp_hold_data", 64'(a_out_data), 64'(pd));
        chk("bp_hold_seq", 64'(a_out_seq), 64'(ps));
      end
    end
    a_in_vld  = 1'b0;
    a_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bp_sb_left", 64'(sb_q.size()), 64'(0));
    chk("bp_drop", 64'(a_drop), 64'(0));
    chk("bp_level", 64'(a_level), 64'(0));

    // Decimation by 3 on instance B: keeps 0, 3, 6 tagged 0, 1, 2.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b_in_vld  = (i < 9);
      b_in_cyc  = 32'(i);
      b_out_rdy = 1'b1;
      step();
      ev = (i < 9) && (i % 3 == 0);
      chk($sformatf("dec%0d_vld", i), 64'(b_out_vld), 64'(ev));
      chk($sformatf("dec%0d_level", i), 64'(b_level), ev ? 64'(1) : 64'(0));
      if (ev) begin
        chk($sformatf("dec%0d_data", i), 64'(b_out_data), 64'(i));
        chk($sformatf("dec%0d_seq", i), 64'(b_out_seq), 64'(i / 3));
      end
    end
    chk("dec_drop", 64'(b_drop), 64'(0));
    chk("dec_done", 64'(b_done), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cyc_sampler.md
Name: cyc_sampler

Overview:
- Downstream consumer of the free-running cycle counter produced by the traced sub-block.
- Takes one counter value per valid cycle and decimates the stream by a fixed ratio.
- Tags each kept sample with a sequence number and buffers it in a small FIFO.
- Presents samples to a trace/monitor sink over a valid/ready handshake, counts overflow drops, and raises a sticky done flag when the finish cycle is seen.

Parameters:
- WIDTH, 32: counter/sample data width.
- DEPTH, 4: FIFO entries. Must be a power of 2 and ≥ 2.
- DECIM, 1: keep every DECIM-th valid input. Must be ≥ 1.
- FINISH_CYC, 5: input value that terminates sampling.

Ports:
- clk  input  1  sole clock, rising edge.
- reset_l  input  1  synchronous reset, active low.
- in_vld  input  1  in_cyc is valid this cycle.
- in_cyc  input  WIDTH  upstream cycle count.
- out_vld  output  1  FIFO head valid.
- out_rdy  input  1  sink accepts head this cycle.
- out_data  output  WIDTH  head sample value.
- out_seq  output  8  head sample sequence number.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  16  samples lost to a full FIFO.
- done  output  1  sticky finish indication.

Behaviour:
- Reset: reset_l is sampled on the clk rising edge. While low, the following are cleared: out_vld=0, out_data=0, out_seq=0, level=0, drop_cnt=0, done=0, decimation counter=0, sequence counter=0, FIFO pointers=0.
- Reset asserted mid-operation discards all FIFO contents in that cycle.
- Accept rule: an input is accepted when in_vld=1 and done=0. While done=1, in_vld is ignored entirely.
- Decimation:
  - dec_cnt advances on each accepted input and wraps from DECIM-1 to 0.
  - An input is "taken" when dec_cnt==0 before the increment.
  - With DECIM=1, every accepted input is taken.
- Sequence:
  - seq_cnt increments on every taken sample, whether it is pushed or dropped, and wraps 255→0.
  - The pushed entry carries the pre-increment seq_cnt value. Gaps in out_seq therefore expose drops.
- Push:
  - A taken sample is pushed if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - Otherwise it is dropped, and drop_cnt increments, saturating at 16'hFFFF.
- Pop: occurs when out_vld && out_rdy.
- FIFO outputs:
  - The FIFO is first-word-fall-through.
  - out_vld = (level!=0), registered.
  - out_data and out_seq always show the head entry. They hold stable while out_vld=1 and out_rdy=0.
- Latency: a sample taken at edge N into an empty FIFO shows out_vld=1 after edge N.
- Simultaneous push and pop:
  - level is unchanged.
  - When empty, a push with no pop makes the entry visible next cycle. No bypass is allowed within the same cycle.
- level behaviour: level increments on push-only, decrements on pop-only, and never exceeds DEPTH or underflows.
- Pointers: read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Finish:
  - done is set at the edge where an accepted in_cyc==FINISH_CYC is seen, independent of decimation.
  - That same input is still decimated and pushed or dropped normally.
  - done stays 1 until reset.
  - The FIFO continues to drain after done.
- Comparisons are unsigned WIDTH-bit. in_cyc wrap-around needs no special handling.

Decomposition:
- Package cyc_sampler_pkg contains:
  - the SEQ_W=8 and DROP_W=16 constants;
  - a typedef sample_t: packed struct {seq[SEQ_W], data[WIDTH]}, parameterised via WIDTH localparam defaults;
  - the drop saturation constant.
- Sub-module cyc_sampler_fifo:
  - a generic sync FWFT FIFO of sample_t with push/pop/level and the same reset;
  - instantiated once.
- All decimation, sequence, drop and done logic lives in the top module.

Test Plan:
- Reset, DECIM=1, out_rdy=1, in_cyc 0..5 on consecutive cycles:
  - out_data sequence is 0,1,2,3,4,5 with out_seq 0..5, each one cycle after its input;
  - done=1 after the edge carrying 5;
  - further inputs produce no output.
- DECIM=3, out_rdy=1, in_cyc 0..8:
  - outputs are 0,3,6 with out_seq 0,1,2;
  - drop_cnt=0.
- DEPTH=4, out_rdy=0, in_cyc 10..15:
  - level reaches 4 and drop_cnt=2;
  - then out_rdy=1 drains 10,11,12,13 with out_seq 0,1,2,3, and the next push shows seq 6.
- FIFO full with out_rdy=1 and in_vld=1 in the same cycle:
  - the push is accepted, level stays 4, drop_cnt is unchanged.
- Backpressure: out_rdy toggles every cycle:
  - out_data and out_seq stay stable while stalled;
  - no duplicated or missing seq values.
- reset_l low for one cycle with 3 entries queued and done=1:
  - out_vld=0, level=0, drop_cnt=0, done=0 the next cycle;
  - the next sample carries out_seq 0.
